inter_ref_req_tiler: RTL and testbench



---
 rtl/inter_req_pkg.sv | 51 +++++
 rtl/inter_ref_tile_calc.sv | 71 +++++++
 rtl/inter_ref_req_tiler.sv | 150 +++++++++++++++
 tb/tb_inter_ref_req_tiler.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/inter_req_pkg.sv
// Shared types and constants for the inter reference-request tiler.
// Optional chroma request fields are compiled in with INTER_REQ_CHMA_EN.
package inter_req_pkg;

  localparam int POS_W  = 14;
  localparam int TILE_W = 8;
  localparam int TILE_H = 8;

  // Interpolation filter margins: pixels before the block, extra extent
  localparam int LUMA_PRE = 3;
  localparam int LUMA_EXT = 7;
  localparam int CHMA_PRE = 1;
  localparam int CHMA_EXT = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [6:0]  w;
    logic [6:0]  h;
    logic [15:0] mv_x;
    logic [15:0] mv_y;
  } pu_desc_t;

  typedef struct packed {
    logic [POS_W-1:0] start_x;
    logic [POS_W-1:0] start_y;
    logic [6:0]       width;
    logic [6:0]       height;
    logic [1:0]       frac_x;
    logic [1:0]       frac_y;
`ifdef INTER_REQ_CHMA_EN
    logic [POS_W-1:0] c_start_x;
    logic [POS_W-1:0] c_start_y;
    logic [5:0]       c_width;
    logic [5:0]       c_height;
    logic [2:0]       c_frac_x;
    logic [2:0]       c_frac_y;
`endif
  } req_t;

  // PU dimension is legal when non-zero, a multiple of 4 and at most 64
  function automatic logic size_ok(input logic [6:0] s);
    return (s != 7'd0) && (s[1:0] == 2'b00) && (s <= 7'd64);
  endfunction

endpackage

// File: rtl/inter_ref_tile_calc.sv
// Combinational tile geometry: maps a PU descriptor and tile offset to the
// reference-block request fields and the last-tile flag.
// Chroma fields are produced when INTER_REQ_CHMA_EN is defined.
module inter_ref_tile_calc
  import inter_req_pkg::*;
(
  input  pu_desc_t   desc_i,
  input  logic [6:0] tx_i,
  input  logic [6:0] ty_i,
  output req_t       req_o,
  output logic       last_o
);

  localparam int PW1 = POS_W + 1;

  logic [6:0]        rem_w, rem_h, tw, th;
  logic signed [15:0] mi_x, mi_y;
  logic [1:0]        fx, fy;
  logic [PW1-1:0]    base_x, base_y, sx, sy;
`ifdef INTER_REQ_CHMA_EN
  logic signed [15:0] ci_x, ci_y;
  logic [2:0]        cfx, cfy;
  logic [PW1-1:0]    csx, csy;
`endif

  // Tile extent, luma start/size, and (optionally) chroma start/size
  always_comb begin
    rem_w  = desc_i.w - tx_i;
    rem_h  = desc_i.h - ty_i;
    tw     = (rem_w > 7'(TILE_W)) ? 7'(TILE_W) : rem_w;
    th     = (rem_h > 7'(TILE_H)) ? 7'(TILE_H) : rem_h;

    mi_x   = $signed(desc_i.mv_x) >>> 2;
    mi_y   = $signed(desc_i.mv_y) >>> 2;
    fx     = desc_i.mv_x[1:0];
    fy     = desc_i.mv_y[1:0];

    // Work one bit wider than POS_W, then truncate to the output width
    base_x = PW1'(desc_i.x) + PW1'(tx_i);
    base_y = PW1'(desc_i.y) + PW1'(ty_i);
    sx     = base_x + PW1'(mi_x) - ((fx != 2'd0) ? PW1'(LUMA_PRE) : '0);
    sy     = base_y + PW1'(mi_y) - ((fy != 2'd0) ? PW1'(LUMA_PRE) : '0);

    req_o         = '0;
    req_o.start_x = sx[POS_W-1:0];
    req_o.start_y = sy[POS_W-1:0];
    req_o.width   = tw + ((fx != 2'd0) ? 7'(LUMA_EXT) : 7'd0);
    req_o.height  = th + ((fy != 2'd0) ? 7'(LUMA_EXT) : 7'd0);
    req_o.frac_x  = fx;
    req_o.frac_y  = fy;

`ifdef INTER_REQ_CHMA_EN
    // 4:2:0: half-resolution position, eighth-pel chroma phase
    ci_x = $signed(desc_i.mv_x) >>> 3;
    ci_y = $signed(desc_i.mv_y) >>> 3;
    cfx  = desc_i.mv_x[2:0];
    cfy  = desc_i.mv_y[2:0];
    csx  = (base_x >> 1) + PW1'(ci_x) - ((cfx != 3'd0) ? PW1'(CHMA_PRE) : '0);
    csy  = (base_y >> 1) + PW1'(ci_y) - ((cfy != 3'd0) ? PW1'(CHMA_PRE) : '0);
    req_o.c_start_x = csx[POS_W-1:0];
    req_o.c_start_y = csy[POS_W-1:0];
    req_o.c_width   = 6'(tw >> 1) + ((cfx != 3'd0) ? 6'(CHMA_EXT) : 6'd0);
    req_o.c_height  = 6'(th >> 1) + ((cfy != 3'd0) ? 6'(CHMA_EXT) : 6'd0);
    req_o.c_frac_x  = cfx;
    req_o.c_frac_y  = cfy;
`endif

    last_o = ((tx_i + tw) == desc_i.w) && ((ty_i + th) == desc_i.h);
  end

endmodule

// File: rtl/inter_ref_req_tiler.sv
// Splits one PU at a time into raster-ordered tiles and issues one
// reference-block request per tile to the inter reference-pixel cache.
// Handshake: a request transfers on any clock edge where req_valid_out and
// cache_idle_in are both 1; while req_valid_out=1 and cache_idle_in=0 all
// request outputs hold. A PU is taken when pu_valid_in and pu_ready_out are 1.
// Optional chroma request outputs: define INTER_REQ_CHMA_EN.
module inter_ref_req_tiler
  import inter_req_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             pu_valid_in,
  output logic             pu_ready_out,
  input  logic [11:0]      pu_x_in,
  input  logic [11:0]      pu_y_in,
  input  logic [6:0]       pu_w_in,
  input  logic [6:0]       pu_h_in,
  input  logic [15:0]      mv_x_in,
  input  logic [15:0]      mv_y_in,
  output logic             req_valid_out,
  input  logic             cache_idle_in,
  output logic [POS_W-1:0] luma_ref_start_x_out,
  output logic [POS_W-1:0] luma_ref_start_y_out,
  output logic [6:0]       luma_ref_width_x_out,
  output logic [6:0]       luma_ref_height_y_out,
  output logic [1:0]       luma_frac_x_out,
  output logic [1:0]       luma_frac_y_out,
`ifdef INTER_REQ_CHMA_EN
  output logic [POS_W-1:0] chma_ref_start_x_out,
  output logic [POS_W-1:0] chma_ref_start_y_out,
  output logic [5:0]       chma_ref_width_x_out,
  output logic [5:0]       chma_ref_height_y_out,
  output logic [2:0]       ch_frac_x_out,
  output logic [2:0]       ch_frac_y_out,
`endif
  output logic             tile_last_out,
  output logic             err_out,
  output logic             dbg_state_out
);

  state_e     state_q;
  pu_desc_t   desc_q, in_desc, calc_desc;
  logic [6:0] tx_q, ty_q, next_tx, next_ty, calc_tx, calc_ty;
  req_t       req_q, calc_req;
  logic       calc_last;
  logic       req_valid_q, tile_last_q, pu_ready_q, err_q;

  assign in_desc = '{x: pu_x_in, y: pu_y_in, w: pu_w_in, h: pu_h_in,
                     mv_x: mv_x_in, mv_y: mv_y_in};

  // Next raster tile offset, and the calculator input: first tile of the
  // incoming PU while idle, otherwise the tile after the current one
  always_comb begin
    next_tx = tx_q + 7'(TILE_W);
    next_ty = ty_q;
    if (next_tx >= desc_q.w) begin
      next_tx = 7'd0;
      next_ty = ty_q + 7'(TILE_H);
    end
    calc_desc = desc_q;
    calc_tx   = next_tx;
    calc_ty   = next_ty;
    if (state_q == ST_IDLE) begin
      calc_desc = in_desc;
      calc_tx   = 7'd0;
      calc_ty   = 7'd0;
    end
  end

  inter_ref_tile_calc u_calc (
    .desc_i (calc_desc),
    .tx_i   (calc_tx),
    .ty_i   (calc_ty),
    .req_o  (calc_req),
    .last_o (calc_last)
  );

  // Control FSM with registered handshake, request and error outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      desc_q      <= '0;
      tx_q        <= '0;
      ty_q        <= '0;
      req_q       <= '0;
      req_valid_q <= 1'b0;
      tile_last_q <= 1'b0;
      pu_ready_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          pu_ready_q <= 1'b1;
          if (pu_ready_q && pu_valid_in) begin
            desc_q <= in_desc;
            tx_q   <= 7'd0;
            ty_q   <= 7'd0;
            if (size_ok(pu_w_in) && size_ok(pu_h_in)) begin
              req_q       <= calc_req;
              tile_last_q <= calc_last;
              req_valid_q <= 1'b1;
              pu_ready_q  <= 1'b0;
              state_q     <= ST_ISSUE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (cache_idle_in) begin
            if (tile_last_q) begin
              req_valid_q <= 1'b0;
              tile_last_q <= 1'b0;
              pu_ready_q  <= 1'b1;
              state_q     <= ST_IDLE;
            end else begin
              tx_q        <= next_tx;
              ty_q        <= next_ty;
              req_q       <= calc_req;
              tile_last_q <= calc_last;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pu_ready_out          = pu_ready_q;
  assign req_valid_out         = req_valid_q;
  assign tile_last_out         = tile_last_q;
  assign err_out               = err_q;
  assign dbg_state_out         = state_q;
  assign luma_ref_start_x_out  = req_q.start_x;
  assign luma_ref_start_y_out  = req_q.start_y;
  assign luma_ref_width_x_out  = req_q.width;
  assign luma_ref_height_y_out = req_q.height;
  assign luma_frac_x_out       = req_q.frac_x;
  assign luma_frac_y_out       = req_q.frac_y;
`ifdef INTER_REQ_CHMA_EN
  assign chma_ref_start_x_out  = req_q.c_start_x;
  assign chma_ref_start_y_out  = req_q.c_start_y;
  assign chma_ref_width_x_out  = req_q.c_width;
  assign chma_ref_height_y_out = req_q.c_height;
  assign ch_frac_x_out         = req_q.c_frac_x;
  assign ch_frac_y_out         = req_q.c_frac_y;
`endif

endmodule

// File: tb/tb_inter_ref_req_tiler.sv
// Directed bench for inter_ref_req_tiler; chroma checks with INTER_REQ_CHMA_EN.
module tb_inter_ref_req_tiler;

  localparam int RW = 47;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pu_valid = 1'b0;
  logic        pu_ready;
  logic [11:0] pu_x = '0, pu_y = '0;
  logic [6:0]  pu_w = '0, pu_h = '0;
  logic [15:0] mv_x = '0, mv_y = '0;
  logic        req_valid;
  logic        cache_idle = 1'b1;
  logic [13:0] sx, sy;
  logic [6:0]  wx, hy;
  logic [1:0]  fx, fy;
  logic        tile_last, err, dbg_state;
`ifdef INTER_REQ_CHMA_EN
  logic [13:0] csx, csy;
  logic [5:0]  cwx, chy;
  logic [2:0]  cfx, cfy;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [RW-1:0] exp_q[$];

  inter_ref_req_tiler dut (
    .clk                   (clk),
    .reset                 (reset),
    .pu_valid_in           (pu_valid),
    .pu_ready_out          (pu_ready),
    .pu_x_in               (pu_x),
    .pu_y_in               (pu_y),
    .pu_w_in               (pu_w),
    .pu_h_in               (pu_h),
    .mv_x_in               (mv_x),
    .mv_y_in               (mv_y),
    .req_valid_out         (req_valid),
    .cache_idle_in         (cache_idle),
    .luma_ref_start_x_out  (sx),
    .luma_ref_start_y_out  (sy),
    .luma_ref_width_x_out  (wx),
    .luma_ref_height_y_out (hy),
    .luma_frac_x_out       (fx),
    .luma_frac_y_out       (fy),
`ifdef INTER_REQ_CHMA_EN
    .chma_ref_start_x_out  (csx),
    .chma_ref_start_y_out  (csy),
    .chma_ref_width_x_out  (cwx),
    .chma_ref_height_y_out (chy),
    .ch_frac_x_out         (cfx),
    .ch_frac_y_out         (cfy),
`endif
    .tile_last_out         (tile_last),
    .err_out               (err),
    .dbg_state_out         (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk(input int x, input int y, input int w, input int h,
                                       input int f_x, input int f_y, input int last);
    return {14'(x), 14'(y), 7'(w), 7'(h), 2'(f_x), 2'(f_y), 1'(last)};
  endfunction

  // Scoreboard: every transfer must match the head of the expected queue
  always @(negedge clk) begin
    if (!reset && req_valid && cache_idle) begin
      chk("ready_during_req", {63'd0, pu_ready}, 64'd0);
      if (exp_q.size() == 0) chk("extra_req", 64'd1, 64'd0);
      else chk("req", 64'({sx, sy, wx, hy, fx, fy, tile_last}), 64'(exp_q.pop_front()));
    end
  end

  // Driver: wait (bounded) for ready, then present one PU for one cycle
  task automatic send_pu(input int x, input int y, input int w, input int h,
                         input int mx, input int my);
    int k;
    for (k = 0; k < 100 && !pu_ready; k++) begin
      @(posedge clk); #1;
    end
    if (!pu_ready) chk("ready_timeout", 64'd0, 64'd1);
    pu_valid = 1'b1;
    pu_x = 12'(x); pu_y = 12'(y); pu_w = 7'(w); pu_h = 7'(h);
    mv_x = 16'(mx); mv_y = 16'(my);
    @(posedge clk); #1;
    pu_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    chk("ready_after_pu", {63'd0, pu_ready}, 64'd1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {63'd0, pu_ready}, 64'd0);
    chk("rst_valid", {63'd0, req_valid}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_last", {63'd0, tile_last}, 64'd0);
    chk("rst_data", 64'({sx, sy, wx, hy, fx, fy}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", {63'd0, pu_ready}, 64'd1);

    // 8x8 at (64,32), zero MV
    exp_q.push_back(mk(64, 32, 8, 8, 0, 0, 1));
    send_pu(64, 32, 8, 8, 0, 0);
    chk("first_req_latency", {63'd0, req_valid}, 64'd1);
    drain();

    // Same PU, mv (5,-6)
    exp_q.push_back(mk(62, 27, 15, 15, 1, 2, 1));
    send_pu(64, 32, 8, 8, 5, -6);
    drain();

    // 16x12 at origin: four tiles
    exp_q.push_back(mk(0, 0, 8, 8, 0, 0, 0));
    exp_q.push_back(mk(8, 0, 8, 8, 0, 0, 0));
    exp_q.push_back(mk(0, 8, 8, 4, 0, 0, 0));
    exp_q.push_back(mk(8, 8, 8, 4, 0, 0, 1));
    send_pu(0, 0, 16, 12, 0, 0);
    drain();

    // Partial-width tile with fractional MV
    exp_q.push_back(mk(5, 5, 15, 11, 3, 1, 0));
    exp_q.push_back(mk(13, 5, 11, 11, 3, 1, 1));
    send_pu(8, 8, 12, 4, 3, 1);
    drain();

    // Negative start, no clamping
    exp_q.push_back(mk(-6, -4, 11, 11, 3, 3, 1));
    send_pu(0, 0, 4, 4, -9, -1);
    drain();

    // Widest legal PU: 64x4, eight tiles in a row
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(4000 + 8 * i, 0, 8, 4, 0, 0, (i == 7) ? 1 : 0));
    send_pu(4000, 0, 64, 4, 0, 0);
    drain();

    // Stall after the first tile of a 16x16 PU
    exp_q.push_back(mk(99, 202, 8, 8, 0, 0, 0));
    exp_q.push_back(mk(107, 202, 8, 8, 0, 0, 0));
    exp_q.push_back(mk(99, 210, 8, 8, 0, 0, 0));
    exp_q.push_back(mk(107, 210, 8, 8, 0, 0, 1));
    send_pu(100, 200, 16, 16, -4, 8);
    @(posedge clk); #1;
    cache_idle = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold", 64'({req_valid, pu_ready, sx, sy, wx, hy, tile_last}),
          64'({1'b1, 1'b0, 14'd107, 14'd202, 7'd8, 7'd8, 1'b0}));
    end
    @(posedge clk); #1;
    cache_idle = 1'b1;
    drain();

    // Illegal sizes: 6 wide, 68 wide, 0 high
    send_pu(0, 0, 6, 8, 0, 0);
    chk("err_w6", 64'({err, pu_ready, req_valid}), 64'({1'b1, 1'b1, 1'b0}));
    @(posedge clk); #1;
    chk("err_w6_pulse", 64'({err, pu_ready, req_valid}), 64'({1'b0, 1'b1, 1'b0}));
    send_pu(0, 0, 68, 8, 0, 0);
    chk("err_w68", {63'd0, err}, 64'd1);
    send_pu(0, 0, 8, 0, 0, 0);
    chk("err_h0", 64'({err, req_valid}), 64'({1'b1, 1'b0}));
    @(posedge clk); #1;
    chk("err_h0_pulse", {63'd0, err}, 64'd0);

    // Reset mid-PU discards it
    cache_idle = 1'b0;
    send_pu(0, 0, 16, 16, 0, 0);
    chk("midpu_valid", {63'd0, req_valid}, 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midpu_reset", 64'({req_valid, pu_ready, tile_last, sx}), 64'd0);
    reset = 1'b0;
    cache_idle = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_midpu_reset", {63'd0, pu_ready}, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("no_req_after_reset", {63'd0, req_valid}, 64'd0);

`ifdef INTER_REQ_CHMA_EN
    // Chroma fields for 8x8 at (64,32), mv (5,0)
    cache_idle = 1'b0;
    exp_q.push_back(mk(62, 32, 15, 8, 1, 0, 1));
    send_pu(64, 32, 8, 8, 5, 0);
    @(negedge clk);
    chk("chroma", 64'({csx, csy, cwx, chy, cfx, cfy}),
        64'({14'd31, 14'd16, 6'd7, 6'd4, 3'd5, 3'd0}));
    @(posedge clk); #1;
    cache_idle = 1'b1;
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
